// File: rtl/axi_lite_reg_pkg.sv
// Types and helpers for the AXI4-Lite register target: decode result and address LSB math.
package axi_lite_reg_pkg;

  // Widest index needed for the largest supported bank (256 registers).
  localparam int unsigned MaxIdxWidth = 8;

  typedef struct packed {
    logic [MaxIdxWidth-1:0] idx;
    logic                   err_dec;
    logic                   err_prot;
  } decode_t;

  // Number of byte-offset address bits ignored by the register decode.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes used by every AXI block in the slice.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_reg_target_if.sv
// AXI4-Lite bus bundle with Initiator and Target views.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);

  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;

  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Initiator (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Target (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/axi_lite_reg_decode.sv
// Combinational address/prot decode for one AXI4-Lite address channel.
// Define AXI_LITE_REG_PROT_CHECK_EN to flag unprivileged (prot[0]=0) accesses.
module axi_lite_reg_decode
  import axi_lite_reg_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs   = 8
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           prot_i,
  output decode_t              dec_o
);

  localparam int unsigned Lsb  = addr_lsb(DataWidth);
  localparam int unsigned IdxW = $clog2(NumRegs);

  logic unused_prot;

  always_comb begin
    dec_o         = '0;
    dec_o.idx     = MaxIdxWidth'(addr_i[Lsb +: IdxW]);
    // Any set bit above the index field addresses nothing in this bank.
    dec_o.err_dec = |(addr_i >> (Lsb + IdxW));
`ifdef AXI_LITE_REG_PROT_CHECK_EN
    dec_o.err_prot = ~prot_i[0];
`else
    dec_o.err_prot = 1'b0;
`endif
  end

  assign unused_prot = ^prot_i;

endmodule

// File: rtl/axi_lite_reg_target.sv
// AXI4-Lite target exposing a bank of word-wide control/status registers.
// Optional AXI_LITE_REG_PROT_CHECK_EN rejects unprivileged accesses with SLVERR.
module axi_lite_reg_target
  import axi_lite_reg_pkg::*;
#(
  parameter int unsigned                          AXI_ADDR_WIDTH = 32,
  parameter int unsigned                          AXI_DATA_WIDTH = 32,
  parameter int unsigned                          NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0]                  RO_MASK        = '0,
  parameter logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   RESET_VAL      = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  AXI_LITE.Target                              axi,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]                  reg_wr_o,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_d_i
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam int unsigned IdxW  = $clog2(NUM_REGS);

  typedef logic [AXI_DATA_WIDTH-1:0] word_t;

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_dw
    $error("AXI_DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_nr
    $error("NUM_REGS must be a power of two in 2..256");
  end

  // Write holding registers
  logic                      aw_held_q, aw_held_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]                aw_prot_q, aw_prot_d;
  logic                      w_held_q, w_held_d;
  word_t                     w_data_q, w_data_d;
  logic [StrbW-1:0]          w_strb_q, w_strb_d;

  logic                      b_valid_q, b_valid_d;
  axi_pkg::resp_t            b_resp_q, b_resp_d;

  logic                      r_valid_q, r_valid_d;
  word_t                     r_data_q, r_data_d;
  axi_pkg::resp_t            r_resp_q, r_resp_d;

  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] reg_d_arr;
  logic [NUM_REGS-1:0]                     wr_q, wr_d;

  logic           aw_ready, w_ready, ar_ready;
  logic           aw_hs, w_hs, ar_hs, wr_commit;
  decode_t        aw_dec, ar_dec;
  logic [IdxW-1:0] aw_idx, ar_idx;
  axi_pkg::resp_t wr_resp;

  assign reg_d_arr = reg_d_i;

  axi_lite_reg_decode #(
    .AddrWidth (AXI_ADDR_WIDTH),
    .DataWidth (AXI_DATA_WIDTH),
    .NumRegs   (NUM_REGS)
  ) u_aw_decode (
    .addr_i (aw_addr_q),
    .prot_i (aw_prot_q),
    .dec_o  (aw_dec)
  );

  axi_lite_reg_decode #(
    .AddrWidth (AXI_ADDR_WIDTH),
    .DataWidth (AXI_DATA_WIDTH),
    .NumRegs   (NUM_REGS)
  ) u_ar_decode (
    .addr_i (axi.ar_addr),
    .prot_i (axi.ar_prot),
    .dec_o  (ar_dec)
  );

  assign aw_idx = aw_dec.idx[IdxW-1:0];
  assign ar_idx = ar_dec.idx[IdxW-1:0];

  // Readies are forced low combinationally so nothing handshakes during reset.
  assign aw_ready = ~rst_i & ~aw_held_q;
  assign w_ready  = ~rst_i & ~w_held_q;
  assign ar_ready = ~rst_i & ~r_valid_q;

  assign aw_hs     = axi.aw_valid & aw_ready;
  assign w_hs      = axi.w_valid & w_ready;
  assign ar_hs     = axi.ar_valid & ar_ready;
  assign wr_commit = aw_held_q & w_held_q & (~b_valid_q | axi.b_ready);

  always_comb begin
    if (aw_dec.err_dec) begin
      wr_resp = axi_pkg::RESP_DECERR;
    end else if (aw_dec.err_prot || RO_MASK[aw_idx]) begin
      wr_resp = axi_pkg::RESP_SLVERR;
    end else begin
      wr_resp = axi_pkg::RESP_OKAY;
    end
  end

  // Write path: independent AW/W capture, commit once both are held and B can be loaded.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    regs_d    = regs_q;
    wr_d      = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = axi.aw_addr;
      aw_prot_d = axi.aw_prot;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = axi.w_data;
      w_strb_d = axi.w_strb;
    end

    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = wr_resp;
      if (wr_resp == axi_pkg::RESP_OKAY && |w_strb_q) begin
        for (int unsigned k = 0; k < StrbW; k++) begin
          if (w_strb_q[k]) begin
            regs_d[aw_idx][8*k +: 8] = w_data_q[8*k +: 8];
          end
        end
        wr_d[aw_idx] = 1'b1;
      end
    end else if (axi.b_ready) begin
      b_valid_d = 1'b0;
    end
  end

  // Read path: reads sample the pre-commit register value, so a same-edge write is not seen.
  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      if (ar_dec.err_dec) begin
        r_resp_d = axi_pkg::RESP_DECERR;
        r_data_d = '0;
      end else if (ar_dec.err_prot) begin
        r_resp_d = axi_pkg::RESP_SLVERR;
        r_data_d = '0;
      end else begin
        r_resp_d = axi_pkg::RESP_OKAY;
        r_data_d = RO_MASK[ar_idx] ? reg_d_arr[ar_idx] : regs_q[ar_idx];
      end
    end else if (axi.r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= axi_pkg::RESP_OKAY;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= axi_pkg::RESP_OKAY;
      regs_q    <= RESET_VAL;
      wr_q      <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      regs_q    <= regs_d;
      wr_q      <= wr_d;
    end
  end

  assign axi.aw_ready = aw_ready;
  assign axi.w_ready  = w_ready;
  assign axi.ar_ready = ar_ready;
  assign axi.b_valid  = b_valid_q;
  assign axi.b_resp   = b_resp_q;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;

  assign reg_q_o  = regs_q;
  assign reg_wr_o = wr_q;

endmodule

// File: tb/tb_axi_lite_reg_target.sv
// Self-checking bench for axi_lite_reg_target: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_axi_lite_reg_target;

  localparam int unsigned NR = 8;
  localparam int unsigned DW = 32;
  localparam logic [NR-1:0] RO = 8'h08;
  localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                     32'h0300_0003, 32'hCAFE_0000, 32'h0, 32'h0};

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [NR*DW-1:0] reg_q_o;
  logic [NR*DW-1:0] reg_d_i;
  logic [NR-1:0]    reg_wr_o;

  AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW)) axi ();

  axi_lite_reg_target #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (DW),
    .NUM_REGS       (NR),
    .RO_MASK        (RO),
    .RESET_VAL      (RV)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .axi      (axi),
    .reg_q_o  (reg_q_o),
    .reg_wr_o (reg_wr_o),
    .reg_d_i  (reg_d_i)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0]    m [NR];
  logic [NR-1:0]    ro_mask = RO;
  logic [NR*DW-1:0] rv_vec  = RV;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m[i] = rv_vec[i*DW +: DW];
  endtask

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m[i];
    return v;
  endfunction

  function automatic logic prot_bad(input logic [2:0] p);
`ifdef AXI_LITE_REG_PROT_CHECK_EN
    return ~p[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] addr, input logic [2:0] p);
    int unsigned idx = (addr / 4) % NR;
    if (addr / (4 * NR) != 0) return 2'b11;
    if (prot_bad(p) || ro_mask[idx]) return 2'b10;
    return 2'b00;
  endfunction

  // Applies a write to the model and returns the expected reg_wr_o pulse.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] p,
                             output logic [NR-1:0] wr);
    int unsigned idx = (addr / 4) % NR;
    wr = '0;
    if (exp_wresp(addr, p) == 2'b00 && strb != 4'h0) begin
      for (int k = 0; k < 4; k++) if (strb[k]) m[idx][8*k +: 8] = data[8*k +: 8];
      wr[idx] = 1'b1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] p,
                          output logic [1:0] resp, output logic [NR-1:0] wr, output bit ok);
    bit aw_done = 0, w_done = 0, a_rdy, w_rdy;
    int n = 0;
    axi.aw_addr = addr; axi.aw_prot = p; axi.aw_valid = 1'b1;
    axi.w_data = data; axi.w_strb = strb; axi.w_valid = 1'b1;
    axi.b_ready = 1'b1;
    ok = 0; resp = 2'bxx; wr = 'x;
    while (!(aw_done && w_done) && n < 50) begin
      a_rdy = axi.aw_ready; w_rdy = axi.w_ready;
      tick(); n++;
      if (a_rdy && axi.aw_valid) begin aw_done = 1; axi.aw_valid = 1'b0; end
      if (w_rdy && axi.w_valid) begin w_done = 1; axi.w_valid = 1'b0; end
    end
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    n = 0;
    while (!axi.b_valid && n < 50) begin tick(); n++; end
    if (axi.b_valid) begin ok = 1; resp = axi.b_resp; wr = reg_wr_o; end
    tick();
    axi.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] p,
                         output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit a_rdy;
    int n = 0;
    axi.ar_addr = addr; axi.ar_prot = p; axi.ar_valid = 1'b1; axi.r_ready = 1'b1;
    ok = 0; data = 'x; resp = 2'bxx;
    while (n < 50) begin
      a_rdy = axi.ar_ready;
      tick(); n++;
      if (a_rdy) break;
    end
    axi.ar_valid = 1'b0;
    n = 0;
    while (!axi.r_valid && n < 50) begin tick(); n++; end
    if (axi.r_valid) begin ok = 1; data = axi.r_data; resp = axi.r_resp; end
    tick();
    axi.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    rst_i = 1'b1;
    model_reset();
    repeat (3) begin
      tick();
      total++;
      if ({axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid} !== 5'b0)
        $display("FAIL reset_handshake: got %b want 00000",
                 {axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid});
      else passed++;
    end
    total++;
    if ({axi.b_resp, axi.r_resp, axi.r_data, reg_wr_o} !== '0)
      $display("FAIL reset_resp: got %h want 0", {axi.b_resp, axi.r_resp, axi.r_data, reg_wr_o});
    else passed++;
    total++;
    if (reg_q_o !== RV) $display("FAIL reset_regs: got %h want %h", reg_q_o, RV);
    else passed++;
    rst_i = 1'b0;
    tick();
    do_read(32'h8, 3'b001, d, r, ok);
    total++;
    if (!ok || d !== 32'hCAFE_0000 || r !== 2'b00)
      $display("FAIL reset_read: got ok=%0d %h/%b want 1 cafe0000/00", ok, d, r);
    else passed++;
  endtask

  task automatic test_ordering();
    axi.b_ready = 1'b0;
    axi.w_data = 32'h1122_3344; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
    total++;
    if (axi.w_ready !== 1'b1) $display("FAIL w_ready_idle: got %b want 1", axi.w_ready);
    else passed++;
    tick(); axi.w_valid = 1'b0;
    tick();
    axi.aw_addr = 32'h4; axi.aw_prot = 3'b001; axi.aw_valid = 1'b1;
    tick(); axi.aw_valid = 1'b0;
    total++;
    if (axi.b_valid !== 1'b0) $display("FAIL b_early: got %b want 0", axi.b_valid);
    else passed++;
    tick();
    total++;
    if (axi.b_valid !== 1'b1 || axi.b_resp !== 2'b00 || reg_q_o[63:32] !== 32'h1122_3344 ||
        reg_wr_o !== 8'h02)
      $display("FAIL order_commit: got b=%b/%b reg1=%h wr=%h want 1/00 11223344 02",
               axi.b_valid, axi.b_resp, reg_q_o[63:32], reg_wr_o);
    else passed++;
    tick();
    total++;
    if (reg_wr_o !== 8'h00 || axi.b_valid !== 1'b1)
      $display("FAIL wr_pulse_once: got wr=%h b=%b want 00 1", reg_wr_o, axi.b_valid);
    else passed++;
    axi.b_ready = 1'b1; tick(); axi.b_ready = 1'b0;
    total++;
    if (axi.b_valid !== 1'b0) $display("FAIL b_release: got %b want 0", axi.b_valid);
    else passed++;
    m[1] = 32'h1122_3344;
  endtask

  task automatic test_strobe_and_errors();
    logic [1:0] r; logic [NR-1:0] wr, ewr; logic [31:0] d; bit ok;
    model_write(32'h4, 32'hAABB_CCDD, 4'b0101, 3'b001, ewr);
    do_write(32'h4, 32'hAABB_CCDD, 4'b0101, 3'b001, r, wr, ok);
    total++;
    if (!ok || r !== 2'b00 || wr !== 8'h02 || reg_q_o[63:32] !== 32'h11BB_33DD)
      $display("FAIL partial_strobe: got ok=%0d %b wr=%h reg1=%h want 1 00 02 11bb33dd",
               ok, r, wr, reg_q_o[63:32]);
    else passed++;
    do_write(32'hC, 32'hFFFF_FFFF, 4'hF, 3'b001, r, wr, ok);
    total++;
    if (!ok || r !== 2'b10 || wr !== 8'h00 || reg_q_o !== model_vec())
      $display("FAIL ro_write: got ok=%0d %b wr=%h want 1 10 00 regs unchanged", ok, r, wr);
    else passed++;
    do_write(32'h40, 32'h1234_5678, 4'hF, 3'b001, r, wr, ok);
    total++;
    if (!ok || r !== 2'b11 || wr !== 8'h00 || reg_q_o !== model_vec())
      $display("FAIL decerr_write: got ok=%0d %b wr=%h want 1 11 00", ok, r, wr);
    else passed++;
    do_write(32'h18, 32'h1234_5678, 4'h0, 3'b001, r, wr, ok);
    total++;
    if (!ok || r !== 2'b00 || wr !== 8'h00 || reg_q_o !== model_vec())
      $display("FAIL zero_strobe: got ok=%0d %b wr=%h want 1 00 00", ok, r, wr);
    else passed++;
    do_read(32'h100, 3'b001, d, r, ok);
    total++;
    if (!ok || r !== 2'b11 || d !== 32'h0)
      $display("FAIL decerr_read: got ok=%0d %h/%b want 1 0/11", ok, d, r);
    else passed++;
    reg_d_i = {8{32'h5EED_0000}} ^ {8{$urandom}};
    do_read(32'hC, 3'b001, d, r, ok);
    total++;
    if (!ok || r !== 2'b00 || d !== reg_d_i[127:96])
      $display("FAIL ro_read_hw: got %h/%b want %h/00", d, r, reg_d_i[127:96]);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] ewr;
    int n = 0;
    axi.b_ready = 1'b0;
    axi.aw_addr = 32'hC; axi.aw_prot = 3'b001; axi.aw_valid = 1'b1;
    axi.w_data = 32'h1234_5678; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
    tick();
    axi.aw_addr = 32'h10; axi.w_data = 32'h55AA_55AA;
    while (!(axi.aw_ready && axi.w_ready) && n < 20) begin tick(); n++; end
    tick();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (axi.b_valid !== 1'b1 || axi.b_resp !== 2'b10)
        $display("FAIL bp_b_stable: got %b/%b want 1/10", axi.b_valid, axi.b_resp);
      else passed++;
      total++;
      if (reg_q_o[159:128] !== m[4] || axi.aw_ready !== 1'b0)
        $display("FAIL bp_no_commit: got reg4=%h awr=%b want %h 0", reg_q_o[159:128],
                 axi.aw_ready, m[4]);
      else passed++;
      tick();
    end
    model_write(32'h10, 32'h55AA_55AA, 4'hF, 3'b001, ewr);
    axi.b_ready = 1'b1; tick();
    total++;
    if (axi.b_valid !== 1'b1 || axi.b_resp !== 2'b00 || reg_q_o[159:128] !== 32'h55AA_55AA ||
        reg_wr_o !== ewr)
      $display("FAIL bp_second: got %b/%b reg4=%h wr=%h want 1/00 55aa55aa %h",
               axi.b_valid, axi.b_resp, reg_q_o[159:128], reg_wr_o, ewr);
    else passed++;
    tick(); axi.b_ready = 1'b0;
    total++;
    if (axi.b_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", axi.b_valid);
    else passed++;
  endtask

  task automatic test_same_cycle();
    logic [1:0] r; logic [NR-1:0] wr, ewr; bit ok;
    model_write(32'h14, 32'h0102_0304, 4'hF, 3'b001, ewr);
    do_write(32'h14, 32'h0102_0304, 4'hF, 3'b001, r, wr, ok);
    axi.b_ready = 1'b1;
    axi.aw_addr = 32'h14; axi.aw_prot = 3'b001; axi.aw_valid = 1'b1;
    axi.w_data = 32'hDEAD_BEEF; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
    tick();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    axi.ar_addr = 32'h14; axi.ar_prot = 3'b001; axi.ar_valid = 1'b1; axi.r_ready = 1'b0;
    tick();
    axi.ar_valid = 1'b0;
    total++;
    if (axi.r_valid !== 1'b1 || axi.r_data !== 32'h0102_0304 ||
        reg_q_o[191:160] !== 32'hDEAD_BEEF)
      $display("FAIL same_cycle_rw: got rv=%b r=%h reg5=%h want 1 01020304 deadbeef",
               axi.r_valid, axi.r_data, reg_q_o[191:160]);
    else passed++;
    model_write(32'h14, 32'hDEAD_BEEF, 4'hF, 3'b001, ewr);
    axi.r_ready = 1'b1; tick(); axi.r_ready = 1'b0; axi.b_ready = 1'b0;
    total++;
    if (axi.r_valid !== 1'b0 || axi.b_valid !== 1'b0)
      $display("FAIL same_cycle_drain: got rv=%b bv=%b want 0 0", axi.r_valid, axi.b_valid);
    else passed++;
  endtask

  task automatic test_prot();
`ifdef AXI_LITE_REG_PROT_CHECK_EN
    logic [1:0] r; logic [NR-1:0] wr, ewr; logic [31:0] d; bit ok;
    model_write(32'h18, 32'h7777_0000, 4'hF, 3'b000, ewr);
    do_write(32'h18, 32'h7777_0000, 4'hF, 3'b000, r, wr, ok);
    total++;
    if (!ok || r !== 2'b10 || reg_q_o !== model_vec())
      $display("FAIL prot_unpriv_write: got ok=%0d %b want 1 10, no change", ok, r);
    else passed++;
    model_write(32'h18, 32'h7777_0000, 4'hF, 3'b001, ewr);
    do_write(32'h18, 32'h7777_0000, 4'hF, 3'b001, r, wr, ok);
    total++;
    if (!ok || r !== 2'b00 || reg_q_o[223:192] !== 32'h7777_0000)
      $display("FAIL prot_priv_write: got ok=%0d %b reg6=%h want 1 00 77770000",
               ok, r, reg_q_o[223:192]);
    else passed++;
    do_read(32'h18, 3'b010, d, r, ok);
    total++;
    if (!ok || r !== 2'b10 || d !== 32'h0)
      $display("FAIL prot_unpriv_read: got %h/%b want 0/10", d, r);
    else passed++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] addr, data, d, ed; logic [3:0] strb; logic [2:0] p;
    logic [1:0] r, er; logic [NR-1:0] wr, ewr; bit ok; int unsigned idx;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NR; i++) reg_d_i[i*DW +: DW] = $urandom;
      addr = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 4 * NR - 1);
      p    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
      idx  = (addr / 4) % NR;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; strb = 4'($urandom_range(0, 15));
        er = exp_wresp(addr, p);
        model_write(addr, data, strb, p, ewr);
        do_write(addr, data, strb, p, r, wr, ok);
        total++;
        if (!ok || r !== er || wr !== ewr)
          $display("FAIL rand_write a=%h: got ok=%0d %b wr=%h want 1 %b %h",
                   addr, ok, r, wr, er, ewr);
        else passed++;
        total++;
        if (reg_q_o !== model_vec())
          $display("FAIL rand_regs a=%h: got %h want %h", addr, reg_q_o, model_vec());
        else passed++;
      end else begin
        if (addr / (4 * NR) != 0) begin er = 2'b11; ed = '0; end
        else if (prot_bad(p)) begin er = 2'b10; ed = '0; end
        else begin er = 2'b00; ed = ro_mask[idx] ? reg_d_i[idx*DW +: DW] : m[idx]; end
        do_read(addr, p, d, r, ok);
        total++;
        if (!ok || r !== er || d !== ed)
          $display("FAIL rand_read a=%h: got ok=%0d %h/%b want 1 %h/%b", addr, ok, d, r, ed, er);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_drop();
    axi.b_ready = 1'b1;
    axi.aw_addr = 32'h18; axi.aw_prot = 3'b001; axi.aw_valid = 1'b1;
    tick(); axi.aw_valid = 1'b0;
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    model_reset();
    axi.w_data = 32'hABCD_EF01; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
    tick(); axi.w_valid = 1'b0;
    tick(); tick();
    total++;
    if (axi.b_valid !== 1'b0 || reg_q_o !== model_vec() || axi.aw_ready !== 1'b1)
      $display("FAIL reset_drop: got bv=%b awr=%b regs=%h want 0 1 %h",
               axi.b_valid, axi.aw_ready, reg_q_o, model_vec());
    else passed++;
    axi.b_ready = 1'b0;
  endtask

  initial begin
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
    axi.b_ready = 1'b0; axi.r_ready = 1'b0;
    axi.aw_addr = '0; axi.aw_prot = 3'b001; axi.ar_addr = '0; axi.ar_prot = 3'b001;
    axi.w_data = '0; axi.w_strb = '0;
    reg_d_i = '0;
    test_reset();
    test_ordering();
    test_strobe_and_errors();
    test_backpressure();
    test_same_cycle();
    test_prot();
    test_random();
    test_reset_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
